display_unit: RTL and testbench

Output stage of the CPU: captures a 32-bit signed value from the datapath on a `displayWrite` strobe and converts it to decimal with a sequential double-dabble. It then drives the three active-low seven-segment digits `display2`/`display1`/`display0`. The displays hold the last completed value until the next accepted write. `busy` tells the control unit when a new write will be accepted.

---
 rtl/display_unit.sv | 174 +++++++++++++++++
 tb/tb_display_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/display_unit.sv
// -----------------------------------------------------------------------------
// display_unit
//   CPU output stage. On an accepted write strobe the 32-bit signed value is
//   latched, range-checked and converted to BCD with a sequential
//   double-dabble. All three seven-segment digits are then updated together.
//   The digits are active-low, with bits {g,f,e,d,c,b,a}.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous reset, active low
//   displayWrite  in   write strobe, accepted only while busy=0
//   data[31:0]    in   two's-complement value, sampled with the strobe
//   busy          out  conversion in progress, new writes are ignored
//   display2[6:0] out  hundreds digit or sign
//   display1[6:0] out  tens digit
//   display0[6:0] out  units digit
// -----------------------------------------------------------------------------
module display_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        displayWrite,
   input  logic [31:0] data,
   output logic        busy,
   output logic [6:0]  display2,
   output logic [6:0]  display1,
   output logic [6:0]  display0
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CHECK   = 2'd1;
   localparam logic [1:0] S_CONVERT = 2'd2;
   localparam logic [1:0] S_LOAD    = 2'd3;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_R     = 7'b0101111;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   logic [1:0]  state_q, state_d;
   logic [31:0] data_q,  data_d;
   logic [9:0]  bin_q,   bin_d;
   logic [11:0] bcd_q,   bcd_d;
   logic [3:0]  cnt_q,   cnt_d;
   logic        err_q,   err_d;
   logic [6:0]  disp2_q, disp2_d;
   logic [6:0]  disp1_q, disp1_d;
   logic [6:0]  disp0_q, disp0_d;

   logic [31:0] mag;
   logic        in_range;
   logic [11:0] bcd_adj;
   logic [3:0]  hund, tens, units;

   // Magnitude wraps in 32 bits, so 0x80000000 stays huge and fails the range test.
   assign mag      = data_q[31] ? (32'd0 - data_q) : data_q;
   assign in_range = data_q[31] ? (mag <= 32'd99) : (mag <= 32'd999);

   // Double-dabble correction: any nibble of 5 or more becomes >= 8 before the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int n = 0; n < 3; n++) begin
         if (bcd_q[n*4 +: 4] >= 4'd5)
            bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
      end
   end

   assign hund  = bcd_q[11:8];
   assign tens  = bcd_q[7:4];
   assign units = bcd_q[3:0];

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      disp2_d = disp2_q;
      disp1_d = disp1_q;
      disp0_d = disp0_q;
      case (state_q)
         S_IDLE: begin
            if (displayWrite) begin
               data_d  = data;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (!in_range) begin
               err_d   = 1'b1;
               state_d = S_LOAD;
            end else begin
               bin_d   = mag[9:0];
               bcd_d   = 12'd0;
               cnt_d   = 4'd0;
               state_d = S_CONVERT;
            end
         end
         S_CONVERT: begin
            bcd_d = {bcd_adj[10:0], bin_q[9]};
            bin_d = {bin_q[8:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd9)
               state_d = S_LOAD;
         end
         default: begin // S_LOAD
            if (err_q) begin
               disp2_d = SEG_E;
               disp1_d = SEG_R;
               disp0_d = SEG_R;
            end else if (data_q[31]) begin
               disp2_d = SEG_MINUS;
               disp1_d = (tens == 4'd0) ? SEG_BLANK : seg7(tens);
               disp0_d = seg7(units);
            end else begin
               // Leading-zero suppression; the units digit always shows.
               disp2_d = (hund == 4'd0) ? SEG_BLANK : seg7(hund);
               disp1_d = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg7(tens);
               disp0_d = seg7(units);
            end
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         data_q  <= 32'd0;
         bin_q   <= 10'd0;
         bcd_q   <= 12'd0;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
         disp2_q <= SEG_BLANK;
         disp1_q <= SEG_BLANK;
         disp0_q <= SEG_BLANK;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         disp2_q <= disp2_d;
         disp1_q <= disp1_d;
         disp0_q <= disp0_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign display2 = disp2_q;
   assign display1 = disp1_q;
   assign display0 = disp0_q;

endmodule

// File: tb/tb_display_unit.sv
module tb_display_unit;

   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] MI = 7'b0111111;
   localparam logic [6:0] EE = 7'b0000110;
   localparam logic [6:0] RR = 7'b0101111;
   localparam logic [6:0] D0 = 7'b1000000;
   localparam logic [6:0] D1 = 7'b1111001;
   localparam logic [6:0] D2 = 7'b0100100;
   localparam logic [6:0] D3 = 7'b0110000;
   localparam logic [6:0] D4 = 7'b0011001;
   localparam logic [6:0] D5 = 7'b0010010;
   localparam logic [6:0] D7 = 7'b1111000;
   localparam logic [6:0] D9 = 7'b0010000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        displayWrite = 1'b0;
   logic [31:0] data = 32'd0;
   logic        busy;
   logic [6:0]  display2, display1, display0;

   int checks = 0;
   int errors = 0;
   logic [20:0] cur;

   display_unit dut (
      .clk(clk), .reset(reset), .displayWrite(displayWrite), .data(data),
      .busy(busy), .display2(display2), .display1(display1), .display0(display0)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [31:0] v;
      logic [20:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [20:0] act, input logic [20:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b required %b", nm, act, exp);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("idle_timeout", {20'd0, busy}, 21'd0);
   endtask

   task automatic do_write(input string nm, input logic [31:0] v,
                           input logic [20:0] exp, input int lat);
      wait_idle();
      displayWrite = 1'b1;
      data = v;
      @(posedge clk); #1;
      chk({nm, "_busy_rise"}, {20'd0, busy}, 21'd1);
      @(negedge clk);
      displayWrite = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         if (k == lat - 1) begin
            chk({nm, "_hold"}, {display2, display1, display0}, cur);
            chk({nm, "_busy_hold"}, {20'd0, busy}, 21'd1);
         end
         if (k == lat) begin
            chk({nm, "_disp"}, {display2, display1, display0}, exp);
            chk({nm, "_busy_fall"}, {20'd0, busy}, 21'd0);
         end
      end
      cur = exp;
   endtask

   initial begin
      vecs[0]  = '{"p42",   32'd42,         {BL, D4, D2}, 12};
      vecs[1]  = '{"p999",  32'd999,        {D9, D9, D9}, 12};
      vecs[2]  = '{"p0",    32'd0,          {BL, BL, D0}, 12};
      vecs[3]  = '{"p100",  32'd100,        {D1, D0, D0}, 12};
      vecs[4]  = '{"p10",   32'd10,         {BL, D1, D0}, 12};
      vecs[5]  = '{"n7",    -32'sd7,        {MI, BL, D7}, 12};
      vecs[6]  = '{"n99",   -32'sd99,       {MI, D9, D9}, 12};
      vecs[7]  = '{"n10",   -32'sd10,       {MI, D1, D0}, 12};
      vecs[8]  = '{"p1000", 32'd1000,       {EE, RR, RR}, 2};
      vecs[9]  = '{"n100",  -32'sd100,      {EE, RR, RR}, 2};
      vecs[10] = '{"pmin",  32'h8000_0000,  {EE, RR, RR}, 2};
      vecs[11] = '{"p305",  32'd305,        {D3, D0, D5}, 12};

      cur = {BL, BL, BL};
      #12;
      chk("reset_disp", {display2, display1, display0}, {BL, BL, BL});
      chk("reset_busy", {20'd0, busy}, 21'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_disp", {display2, display1, display0}, {BL, BL, BL});
      chk("idle_busy", {20'd0, busy}, 21'd0);

      foreach (vecs[i]) do_write(vecs[i].nm, vecs[i].v, vecs[i].exp, vecs[i].lat);

      // asynchronous reset in the middle of a cycle
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      chk("async_rst_disp", {display2, display1, display0}, {BL, BL, BL});
      chk("async_rst_busy", {20'd0, busy}, 21'd0);
      @(negedge clk);
      reset = 1'b1;
      cur = {BL, BL, BL};

      // strobe at E5 must be ignored
      wait_idle();
      displayWrite = 1'b1; data = 32'd42;
      @(posedge clk);                 // E0
      @(negedge clk); displayWrite = 1'b0;
      repeat (4) @(posedge clk);      // E1..E4
      @(negedge clk); displayWrite = 1'b1; data = 32'd7;
      @(posedge clk); #1;             // E5
      chk("ign_busy_e5", {20'd0, busy}, 21'd1);
      @(negedge clk); displayWrite = 1'b0;
      repeat (7) @(posedge clk);      // E6..E12
      #1;
      chk("ign_disp_e12", {display2, display1, display0}, {BL, D4, D2});
      chk("ign_busy_e12", {20'd0, busy}, 21'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("ign_disp_late", {display2, display1, display0}, {BL, D4, D2});
      chk("ign_busy_late", {20'd0, busy}, 21'd0);
      cur = {BL, D4, D2};

      // strobe on the returning edge is ignored, on the next edge accepted
      wait_idle();
      displayWrite = 1'b1; data = 32'd5;
      @(posedge clk);                 // E0
      @(negedge clk); displayWrite = 1'b0;
      repeat (11) @(posedge clk);     // E1..E11
      @(negedge clk); displayWrite = 1'b1; data = 32'd3;
      @(posedge clk); #1;             // E12
      chk("edge_disp_e12", {display2, display1, display0}, {BL, BL, D5});
      chk("edge_busy_e12", {20'd0, busy}, 21'd0);
      @(posedge clk); #1;             // E13 accepts
      chk("edge_busy_e13", {20'd0, busy}, 21'd1);
      @(negedge clk); displayWrite = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      chk("edge_hold_3", {display2, display1, display0}, {BL, BL, D5});
      @(posedge clk); #1;
      chk("edge_disp_3", {display2, display1, display0}, {BL, BL, D3});
      chk("edge_busy_3", {20'd0, busy}, 21'd0);

      // reset at E6 aborts a conversion
      wait_idle();
      displayWrite = 1'b1; data = 32'd42;
      @(posedge clk);                 // E0
      @(negedge clk); displayWrite = 1'b0;
      repeat (6) @(posedge clk);      // E1..E6
      #1;
      reset = 1'b0;
      #1;
      chk("abort_disp", {display2, display1, display0}, {BL, BL, BL});
      chk("abort_busy", {20'd0, busy}, 21'd0);
      @(negedge clk);
      reset = 1'b1;
      cur = {BL, BL, BL};
      do_write("abort_p5", 32'd5, {BL, BL, D5}, 12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: got running required finished");
      $fatal(1);
   end

endmodule
